// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file writeback arbiter: ALU results, buffered load responses, load scoreboard
// Optional load-response bypass of the FIFO when RF_WB_LD_BYPASS_EN is defined.
module rf_wb_ctrl #(
  parameter int LQ_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd_addr,
  input  logic [XLEN-1:0] i_alu_rd_data,
  input  logic            i_ld_issue,
  input  logic [4:0]      i_ld_issue_rd,
  input  logic            i_ld_rsp_valid,
  input  logic [4:0]      i_ld_rsp_rd,
  input  logic [XLEN-1:0] i_ld_rsp_data,
  output logic            o_ld_rsp_ready,
  input  logic [4:0]      i_dec_rs1_addr,
  input  logic [4:0]      i_dec_rs2_addr,
  input  logic [4:0]      i_dec_rd_addr,
  output logic            o_stall,
  output logic [31:0]     o_busy_mask,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

  logic [4:0]      r_q_rd   [LQ_DEPTH];
  logic [XLEN-1:0] r_q_data [LQ_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_busy;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic            r_rd_wren;

  logic            w_empty;
  logic            w_accept;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_sel;
  logic [4:0]      w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_clr_en;
  logic [31:0]     w_busy_nxt;

  assign w_empty        = (r_count == '0);
  assign o_ld_rsp_ready = (r_count < DEPTH_C);
  assign w_accept       = i_ld_rsp_valid && o_ld_rsp_ready;

`ifdef RF_WB_LD_BYPASS_EN
  assign w_bypass = w_accept && w_empty && !i_alu_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  assign w_pop  = !i_alu_valid && !w_empty;

  // Strict priority: ALU, then FIFO head, then a bypassed response (only possible when empty).
  always_comb begin
    w_wr_sel  = 1'b0;
    w_wr_rd   = i_alu_rd_addr;
    w_wr_data = i_alu_rd_data;
    w_clr_en  = 1'b0;
    if (i_alu_valid) begin
      w_wr_sel = 1'b1;
    end else if (w_pop) begin
      w_wr_sel  = 1'b1;
      w_wr_rd   = r_q_rd[r_rptr];
      w_wr_data = r_q_data[r_rptr];
      w_clr_en  = 1'b1;
    end else if (w_bypass) begin
      w_wr_sel  = 1'b1;
      w_wr_rd   = i_ld_rsp_rd;
      w_wr_data = i_ld_rsp_data;
      w_clr_en  = 1'b1;
    end
  end

  // Set is applied after clear so a fresh reservation of the same register survives.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr_en)
      w_busy_nxt[w_wr_rd] = 1'b0;
    if (i_ld_issue && (i_ld_issue_rd != 5'd0))
      w_busy_nxt[i_ld_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= i_ld_rsp_rd;
      r_q_data[r_wptr] <= i_ld_rsp_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rd_wren <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_wr_sel) begin
        r_rd_addr <= w_wr_rd;
        r_rd_data <= w_wr_data;
        r_rd_wren <= (w_wr_rd != 5'd0);
      end else begin
        r_rd_wren <= 1'b0;
      end
    end
  end

  assign o_busy_mask = r_busy;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_data   = r_rd_data;
  assign o_rd_wren   = r_rd_wren;

  assign o_stall = ((i_dec_rs1_addr != 5'd0) && r_busy[i_dec_rs1_addr]) ||
                   ((i_dec_rs2_addr != 5'd0) && r_busy[i_dec_rs2_addr]) ||
                   ((i_dec_rd_addr  != 5'd0) && r_busy[i_dec_rd_addr]);

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - directed self-checking bench for rf_wb_ctrl
module tb_rf_wb_ctrl;
  logic        i_clk;
  logic        i_rst_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd_addr;
  logic [31:0] i_alu_rd_data;
  logic        i_ld_issue;
  logic [4:0]  i_ld_issue_rd;
  logic        i_ld_rsp_valid;
  logic [4:0]  i_ld_rsp_rd;
  logic [31:0] i_ld_rsp_data;
  logic        o_ld_rsp_ready;
  logic [4:0]  i_dec_rs1_addr;
  logic [4:0]  i_dec_rs2_addr;
  logic [4:0]  i_dec_rd_addr;
  logic        o_stall;
  logic [31:0] o_busy_mask;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_ctrl #(.LQ_DEPTH(2), .XLEN(32)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_alu_valid    (i_alu_valid),
    .i_alu_rd_addr  (i_alu_rd_addr),
    .i_alu_rd_data  (i_alu_rd_data),
    .i_ld_issue     (i_ld_issue),
    .i_ld_issue_rd  (i_ld_issue_rd),
    .i_ld_rsp_valid (i_ld_rsp_valid),
    .i_ld_rsp_rd    (i_ld_rsp_rd),
    .i_ld_rsp_data  (i_ld_rsp_data),
    .o_ld_rsp_ready (o_ld_rsp_ready),
    .i_dec_rs1_addr (i_dec_rs1_addr),
    .i_dec_rs2_addr (i_dec_rs2_addr),
    .i_dec_rd_addr  (i_dec_rd_addr),
    .o_stall        (o_stall),
    .o_busy_mask    (o_busy_mask),
    .o_rd_addr      (o_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_rd_wren      (o_rd_wren)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic wren, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_wren"}, 64'(o_rd_wren), 64'(wren));
    check({tag, "_addr"}, 64'(o_rd_addr), 64'(addr));
    check({tag, "_data"}, 64'(o_rd_data), 64'(data));
  endtask

  initial begin
    i_rst_n = 1'b0; i_alu_valid = 1'b0; i_alu_rd_addr = '0; i_alu_rd_data = '0;
    i_ld_issue = 1'b0; i_ld_issue_rd = '0; i_ld_rsp_valid = 1'b0; i_ld_rsp_rd = '0;
    i_ld_rsp_data = '0; i_dec_rs1_addr = '0; i_dec_rs2_addr = '0; i_dec_rd_addr = '0;
    step(); step();
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset_busy", 64'(o_busy_mask), 64'h0);
    check("reset_ready", 64'(o_ld_rsp_ready), 64'h1);
    check("reset_stall", 64'(o_stall), 64'h0);
    i_rst_n = 1'b1;
    step();

    // ALU write, then idle cycle holds address/data
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd5; i_alu_rd_data = 32'h0000_1234;
    step();
    i_alu_valid = 1'b0;
    chk_wr("alu_t1", 1'b1, 5'd5, 32'h1234);
    step();
    chk_wr("alu_t2", 1'b0, 5'd5, 32'h1234);

    // Scoreboard and stall
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7;
    step();
    i_ld_issue = 1'b0;
    check("sb_busy7", 64'(o_busy_mask), 64'h80);
    i_dec_rs1_addr = 5'd7; #1;
    check("sb_stall_rs1", 64'(o_stall), 64'h1);
    i_dec_rs1_addr = 5'd0; i_dec_rd_addr = 5'd7; #1;
    check("sb_stall_rd", 64'(o_stall), 64'h1);
    i_dec_rd_addr = 5'd6; i_dec_rs2_addr = 5'd3; #1;
    check("sb_nostall", 64'(o_stall), 64'h0);
    i_dec_rd_addr = 5'd0; i_dec_rs2_addr = 5'd0; i_dec_rs1_addr = 5'd7;
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd7; i_ld_rsp_data = 32'hDEAD_BEEF;
    step();
    i_ld_rsp_valid = 1'b0;
`ifdef RF_WB_LD_BYPASS_EN
    chk_wr("ld_t1", 1'b1, 5'd7, 32'hDEAD_BEEF);
`else
    check("ld_t1_wren", 64'(o_rd_wren), 64'h0);
    check("ld_t1_busy", 64'(o_busy_mask), 64'h80);
    step();
    chk_wr("ld_t2", 1'b1, 5'd7, 32'hDEAD_BEEF);
`endif
    check("ld_busy_clr", 64'(o_busy_mask), 64'h0);
    check("ld_stall_clr", 64'(o_stall), 64'h0);
    i_dec_rs1_addr = 5'd0;
    step();

    // ALU and load response accepted in the same cycle
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd4; i_alu_rd_data = 32'h44;
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd6; i_ld_rsp_data = 32'h66;
    step();
    i_alu_valid = 1'b0; i_ld_rsp_valid = 1'b0;
    chk_wr("cf_alu", 1'b1, 5'd4, 32'h44);
    step();
    chk_wr("cf_ld", 1'b1, 5'd6, 32'h66);
    step();
    check("cf_idle", 64'(o_rd_wren), 64'h0);

    // FIFO fill under ALU pressure, then in-order drain
    i_ld_issue = 1'b1;
    i_ld_issue_rd = 5'd8;  step();
    i_ld_issue_rd = 5'd9;  step();
    i_ld_issue_rd = 5'd10; step();
    i_ld_issue = 1'b0;
    check("ff_busy", 64'(o_busy_mask), 64'h700);
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd1; i_alu_rd_data = 32'h11;
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd8; i_ld_rsp_data = 32'h80;
    step();
    check("ff_ready1", 64'(o_ld_rsp_ready), 64'h1);
    i_alu_rd_addr = 5'd2; i_alu_rd_data = 32'h22;
    i_ld_rsp_rd = 5'd9; i_ld_rsp_data = 32'h90;
    step();
    check("ff_ready_full", 64'(o_ld_rsp_ready), 64'h0);
    chk_wr("ff_alu2", 1'b1, 5'd2, 32'h22);
    i_alu_rd_addr = 5'd3; i_alu_rd_data = 32'h33;
    i_ld_rsp_rd = 5'd10; i_ld_rsp_data = 32'hA0;
    step();
    i_alu_rd_addr = 5'd4; i_alu_rd_data = 32'h44;
    step();
    check("ff_ready_held", 64'(o_ld_rsp_ready), 64'h0);
    i_alu_valid = 1'b0;
    step();
    chk_wr("ff_w8", 1'b1, 5'd8, 32'h80);
    check("ff_ready_after_pop", 64'(o_ld_rsp_ready), 64'h1);
    step();
    i_ld_rsp_valid = 1'b0;
    chk_wr("ff_w9", 1'b1, 5'd9, 32'h90);
    step();
    chk_wr("ff_w10", 1'b1, 5'd10, 32'hA0);
    check("ff_busy_clr", 64'(o_busy_mask), 64'h0);
    step();
    check("ff_idle", 64'(o_rd_wren), 64'h0);

    // Response to x0 is consumed without a write
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd0; i_ld_rsp_data = 32'hAA;
    step();
    i_ld_rsp_valid = 1'b0;
    check("x0_wren_a", 64'(o_rd_wren), 64'h0);
    step();
    check("x0_wren_b", 64'(o_rd_wren), 64'h0);
    check("x0_ready", 64'(o_ld_rsp_ready), 64'h1);
    check("x0_busy", 64'(o_busy_mask), 64'h0);

    // New reservation of x8 in the same cycle the older x8 load is written
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd8;
    step();
    i_ld_issue = 1'b0;
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd8; i_ld_rsp_data = 32'h8888;
`ifdef RF_WB_LD_BYPASS_EN
    i_ld_issue = 1'b1;
    step();
    i_ld_issue = 1'b0; i_ld_rsp_valid = 1'b0;
`else
    step();
    i_ld_rsp_valid = 1'b0;
    i_ld_issue = 1'b1;
    step();
    i_ld_issue = 1'b0;
`endif
    chk_wr("sw_write", 1'b1, 5'd8, 32'h8888);
    check("sw_busy", 64'(o_busy_mask), 64'h100);

    // Async reset with two entries queued and x8 reserved
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd1; i_alu_rd_data = 32'h1;
    i_ld_rsp_valid = 1'b1; i_ld_rsp_rd = 5'd8; i_ld_rsp_data = 32'hBAD0;
    step(); step();
    check("ar_full", 64'(o_ld_rsp_ready), 64'h0);
    i_dec_rs1_addr = 5'd8;
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_wr("ar_now", 1'b0, 5'd0, 32'h0);
    check("ar_busy", 64'(o_busy_mask), 64'h0);
    check("ar_ready", 64'(o_ld_rsp_ready), 64'h1);
    check("ar_stall", 64'(o_stall), 64'h0);
    i_alu_valid = 1'b0; i_ld_rsp_valid = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();
    check("ar_post1", 64'(o_rd_wren), 64'h0);
    step();
    check("ar_post2", 64'(o_rd_wren), 64'h0);
    step();
    check("ar_post3", 64'(o_rd_wren), 64'h0);
    check("ar_post_ready", 64'(o_ld_rsp_ready), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Writeback controller that drives the single register-file write port (rd address, data, write enable).
- Merges two sources: single-cycle ALU results and variable-latency load responses.
- Load responses are buffered in a small FIFO. A scoreboard of outstanding load destinations lets decode stall on RAW/WAW hazards.
- Sits between the execute/LSU stages and the register file.

Parameters:
- LQ_DEPTH, 2, load-response FIFO depth (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU result valid this cycle; no backpressure
- i_alu_rd_addr  in  5  ALU destination register
- i_alu_rd_data  in  XLEN  ALU result
- i_ld_issue  in  1  load issued; reserves destination register
- i_ld_issue_rd  in  5  destination of issued load
- i_ld_rsp_valid  in  1  load response valid
- i_ld_rsp_rd  in  5  load response destination
- i_ld_rsp_data  in  XLEN  load data
- o_ld_rsp_ready  out  1  FIFO can accept a response
- i_dec_rs1_addr  in  5  decode-stage source 1
- i_dec_rs2_addr  in  5  decode-stage source 2
- i_dec_rd_addr  in  5  decode-stage destination
- o_stall  out  1  decode hazard on a pending load destination
- o_busy_mask  out  32  scoreboard; bit n = load to xn outstanding
- o_rd_addr  out  5  to register file write address
- o_rd_data  out  XLEN  to register file write data
- o_rd_wren  out  1  to register file write enable

Behaviour:
- Reset (async, i_rst_n=0):
  - o_rd_addr, o_rd_data, o_rd_wren, o_busy_mask all 0.
  - FIFO empty, so o_ld_rsp_ready=1 and o_stall=0.
  - Reset mid-operation discards FIFO contents and all scoreboard bits.
- Write port outputs are registered: every source is presented on o_rd_* one cycle after selection.
- Source select each cycle, strict priority:
  1. ALU if i_alu_valid.
  2. Otherwise FIFO head if FIFO not empty.
  3. Otherwise o_rd_wren=0 next cycle, and o_rd_addr/o_rd_data hold their previous values.
- Register x0:
  - Any selected write with rd=0 is consumed (FIFO pops if it was a load) but drives o_rd_wren=0.
  - x0 is never marked busy.
- ALU latency: i_alu_valid at cycle T, so o_rd_wren=1 with ALU addr/data at T+1.
- Load handshake:
  - A response is accepted when i_ld_rsp_valid && o_ld_rsp_ready at a clock edge.
  - o_ld_rsp_ready = (count < LQ_DEPTH), decoded from registered state only, so it has no combinational path from inputs.
  - While the FIFO is full, valid may be held; data must stay stable until accepted.
- Load latency (no bypass):
  - Accepted at edge T, so the entry is at the FIFO head in cycle T+1.
  - It is written at T+2 if no ALU conflict.
  - Each ALU-valid cycle delays it by one cycle.
- FIFO:
  - Circular read/write pointers plus count.
  - Simultaneous push and pop while full is not possible, because ready=0.
  - Simultaneous push and pop at any other count leaves count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- Starvation: continuous i_alu_valid starves the FIFO indefinitely. This is legal; upstream bounds it.
- Scoreboard:
  - Set: bit[i_ld_issue_rd] on i_ld_issue, when rd≠0.
  - Clear: bit[rd] at the edge where a load entry is selected for write.
  - Set and clear of the same bit in the same cycle: set wins (a newer load reservation).
  - A response whose rd is not busy is still written; the clear is a no-op.
- o_stall, combinational:
  - (rs1≠0 & busy[rs1]) | (rs2≠0 & busy[rs2]) | (rd≠0 & busy[rd]).
  - Uses registered o_busy_mask, so it has no path from i_ld_issue.
- Ordering: load responses are written in acceptance order. ALU writes never target a busy register, because decode stalls guarantee this.

Optional Feature:
- Macro: RF_WB_LD_BYPASS_EN.
- Defined:
  - A response accepted while the FIFO is empty and i_alu_valid=0 skips the FIFO.
  - Accepted at T, so written at T+1; its scoreboard bit is cleared at the same edge.
  - In that case the FIFO is not pushed and count stays 0.
  - All other cases are unchanged.
- Undefined: every response goes through the FIFO (minimum latency 2 cycles).

Test Plan:
- ALU only: i_alu_valid=1, rd=5, data=0x0000_1234 at T -> o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234 at T+1; wren=0 at T+2.
- Load scoreboard: issue rd=7, then decode rs1=7 -> o_stall=1 and o_busy_mask=0x80. Response rd=7, data=0xDEADBEEF accepted at T -> write at T+2 (T+1 with RF_WB_LD_BYPASS_EN); busy[7] clears, o_stall=0.
- Conflict: ALU rd=4 and load response rd=6 accepted the same cycle T -> ALU write at T+1, load write at T+2 (both configs).
- FIFO full: i_alu_valid held high 4 cycles with 3 load responses (rd=8,9,10) offered back to back -> ready drops after 2 accepts. When ALU stops, writes come out in order 8, 9, 10 on consecutive cycles, all busy bits clear.
- x0 and set-wins:
  - Load response rd=0 -> popped, o_rd_wren stays 0.
  - Issue rd=8 in the same cycle the older rd=8 load is written -> busy[8] remains 1.
- Async reset: assert i_rst_n=0 mid-cycle with FIFO count 2 and busy=0x100 -> outputs immediately 0, ready=1, stall=0; no stale writes after release.
